// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
// Holds the access FSM state enum and the requester ID encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int ADDR_W_DEF     = 6;
    localparam int DATA_W_DEF     = 64;
    localparam int INSTR_W_DEF    = 32;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and memory port.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();

    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [INSTR_W-1:0] if_rdata;

    logic               d_req;
    logic               d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic               d_gnt;
    logic               d_rvalid;
    logic [DATA_W-1:0]  d_rdata;

    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between fetch and data, data-first with a starvation guard.
// Ports: clk, rst, if_req, d_req, arb_en in; winner, gnt_valid out.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_en,
    output logic winner,
    output logic gnt_valid
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q;
    logic          starved;

    assign starved   = (starve_q == SW'(STARVE_MAX));
    assign gnt_valid = arb_en && (if_req || d_req);
    // Data wins ties unless the pending fetch has been passed over too often.
    assign winner    = (d_req && !(if_req && starved)) ? REQ_D : REQ_IF;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if (!if_req) begin
            starve_q <= '0;
        end else if (gnt_valid) begin
            if (winner == REQ_IF) begin
                starve_q <= '0;
            end else if (!starved) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data ports.
// Ports: clk, rst (sync, active-high), bus (slave modport of the bundle).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               win_q;
    logic               we_q;
    logic               half_q;
    logic [INSTR_W-1:0] if_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;

    logic arb_en;
    logic gnt_valid;
    logic win;
    logic capture;

    // Arbitration happens in IDLE and RESP; reset blocks any grant.
    assign arb_en = !rst && (state_q != WAIT);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .if_req    (bus.if_req),
        .d_req     (bus.d_req),
        .arb_en    (arb_en),
        .winner    (win),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        capture       = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        unique case (state_q)
            IDLE, RESP: begin
                if (gnt_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(MEM_LAT);
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Last wait cycle: mem_rdata is valid now.
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase

        if (gnt_valid) begin
            bus.mem_en = 1'b1;
            if (win == REQ_D) begin
                bus.d_gnt     = 1'b1;
                bus.mem_we    = bus.d_we;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
            end else begin
                bus.if_gnt   = 1'b1;
                // Fetch address counts 32-bit halves; memory counts words.
                bus.mem_addr = {1'b0, bus.if_addr[ADDR_W-1:1]};
            end
        end

        if (!rst && state_q == RESP) begin
            bus.if_rvalid = (win_q == REQ_IF);
            bus.d_rvalid  = (win_q == REQ_D);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_q      <= REQ_IF;
            we_q       <= 1'b0;
            half_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt_valid) begin
                win_q  <= win;
                we_q   <= (win == REQ_D) && bus.d_we;
                half_q <= bus.if_addr[0];
            end
            if (capture && !we_q) begin
                if (win_q == REQ_IF) begin
                    if_rdata_q <= half_q ? bus.mem_rdata[DATA_W-1:INSTR_W]
                                         : bus.mem_rdata[INSTR_W-1:0];
                end else begin
                    d_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vectors plus corner sequences.
// u0 runs with MEM_LAT=1, u1 with MEM_LAT=2 for the mid-access reset case.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [5:0]  Z6  = 6'd0;
    localparam logic [31:0] Z32 = 32'd0;
    localparam logic [63:0] Z64 = 64'd0;
    localparam logic [63:0] M0  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] MA  = 64'hAAAA_BBBB_1111_2222;
    localparam logic [63:0] MW  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] MC  = 64'hCAFE_F00D_5555_6666;
    localparam int NV = 19;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [5:0]  ia;
        logic        dr;
        logic        dw;
        logic [5:0]  da;
        logic [63:0] dwd;
        logic        eig;
        logic        eiv;
        logic [31:0] eird;
        logic        edg;
        logic        edv;
        logic [63:0] edrd;
        logic        emen;
        logic        emwe;
        logic [5:0]  ema;
        logic [63:0] emwd;
    } vec_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(6), .DATA_W(64), .INSTR_W(32)) b0 ();
    mem_port_arbiter_if #(.ADDR_W(6), .DATA_W(64), .INSTR_W(32)) b1 ();

    mem_port_arbiter #(
        .ADDR_W(6), .DATA_W(64), .INSTR_W(32), .MEM_LAT(1), .STARVE_MAX(4)
    ) u0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    mem_port_arbiter #(
        .ADDR_W(6), .DATA_W(64), .INSTR_W(32), .MEM_LAT(2), .STARVE_MAX(4)
    ) u1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    logic [63:0] mem0 [64] = '{0: M0, 2: MA, default: Z64};
    logic [63:0] mem1 [64] = '{9: MC, default: Z64};
    logic [63:0] p1;

    always @(posedge clk) begin
        if (b0.mem_en) begin
            if (b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
            b0.mem_rdata <= mem0[b0.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (b1.mem_en) begin
            if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
            p1 <= mem1[b1.mem_addr];
        end
        b1.mem_rdata <= p1;
    end

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive0(input vec_t v);
        rst0       = v.rst;
        b0.if_req  = v.ir;
        b0.if_addr = v.ia;
        b0.d_req   = v.dr;
        b0.d_we    = v.dw;
        b0.d_addr  = v.da;
        b0.d_wdata = v.dwd;
    endtask

    vec_t vecs [NV];
    logic gnt_seq [10];

    initial begin
        int ng;
        int seen;
        int lat;
        logic got_rv;

        // Reset with both requests high, then contention.
        vecs[0]  = '{H,H,Z6,H,L,Z6,Z64, L,L,Z32,L,L,Z64,L,L,Z6,Z64};
        vecs[1]  = '{H,H,Z6,H,L,Z6,Z64, L,L,Z32,L,L,Z64,L,L,Z6,Z64};
        vecs[2]  = '{L,H,Z6,H,L,Z6,Z64, L,L,Z32,H,L,Z64,H,L,Z6,Z64};
        vecs[3]  = '{L,H,Z6,L,L,Z6,Z64, L,L,Z32,L,L,Z64,L,L,Z6,Z64};
        vecs[4]  = '{L,H,Z6,L,L,Z6,Z64, H,L,Z32,L,H,M0,H,L,Z6,Z64};
        vecs[5]  = '{L,L,Z6,L,L,Z6,Z64, L,L,Z32,L,L,M0,L,L,Z6,Z64};
        vecs[6]  = '{L,L,Z6,L,L,Z6,Z64,
                     L,H,32'h89AB_CDEF,L,L,M0,L,L,Z6,Z64};
        // Single fetches, upper then lower half of word 2.
        vecs[7]  = '{L,H,6'd5,L,L,Z6,Z64,
                     H,L,32'h89AB_CDEF,L,L,M0,H,L,6'd2,Z64};
        vecs[8]  = '{L,L,Z6,L,L,Z6,Z64,
                     L,L,32'h89AB_CDEF,L,L,M0,L,L,Z6,Z64};
        vecs[9]  = '{L,L,Z6,L,L,Z6,Z64,
                     L,H,32'hAAAA_BBBB,L,L,M0,L,L,Z6,Z64};
        vecs[10] = '{L,H,6'd4,L,L,Z6,Z64,
                     H,L,32'hAAAA_BBBB,L,L,M0,H,L,6'd2,Z64};
        vecs[11] = '{L,L,Z6,L,L,Z6,Z64,
                     L,L,32'hAAAA_BBBB,L,L,M0,L,L,Z6,Z64};
        vecs[12] = '{L,L,Z6,L,L,Z6,Z64,
                     L,H,32'h1111_2222,L,L,M0,L,L,Z6,Z64};
        // Write word 7, then back-to-back read of it from RESP.
        vecs[13] = '{L,L,Z6,H,H,6'd7,MW,
                     L,L,32'h1111_2222,H,L,M0,H,H,6'd7,MW};
        vecs[14] = '{L,L,Z6,L,L,Z6,Z64,
                     L,L,32'h1111_2222,L,L,M0,L,L,Z6,Z64};
        vecs[15] = '{L,L,Z6,H,L,6'd7,Z64,
                     L,L,32'h1111_2222,H,H,M0,H,L,6'd7,Z64};
        vecs[16] = '{L,L,Z6,L,L,Z6,Z64,
                     L,L,32'h1111_2222,L,L,M0,L,L,Z6,Z64};
        vecs[17] = '{L,L,Z6,L,L,Z6,Z64,
                     L,L,32'h1111_2222,L,H,MW,L,L,Z6,Z64};
        vecs[18] = '{L,L,Z6,L,L,Z6,Z64,
                     L,L,32'h1111_2222,L,L,MW,L,L,Z6,Z64};

        drive0(vecs[0]);
        rst1       = 1'b1;
        b1.if_req  = 1'b0;
        b1.if_addr = '0;
        b1.d_req   = 1'b0;
        b1.d_we    = 1'b0;
        b1.d_addr  = '0;
        b1.d_wdata = '0;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive0(vecs[i]);
            @(negedge clk);
            chk("if_gnt",    i, 64'(b0.if_gnt),    64'(vecs[i].eig));
            chk("if_rvalid", i, 64'(b0.if_rvalid), 64'(vecs[i].eiv));
            chk("if_rdata",  i, 64'(b0.if_rdata),  64'(vecs[i].eird));
            chk("d_gnt",     i, 64'(b0.d_gnt),     64'(vecs[i].edg));
            chk("d_rvalid",  i, 64'(b0.d_rvalid),  64'(vecs[i].edv));
            chk("d_rdata",   i, b0.d_rdata,        vecs[i].edrd);
            chk("mem_en",    i, 64'(b0.mem_en),    64'(vecs[i].emen));
            chk("mem_we",    i, 64'(b0.mem_we),    64'(vecs[i].emwe));
            chk("mem_addr",  i, 64'(b0.mem_addr),  64'(vecs[i].ema));
            chk("mem_wdata", i, b0.mem_wdata,      vecs[i].emwd);
        end

        // Starvation: both requests held high for ten grants.
        @(posedge clk);
        #1;
        b0.if_req  = 1'b1;
        b0.if_addr = 6'd0;
        b0.d_req   = 1'b1;
        b0.d_we    = 1'b0;
        b0.d_addr  = 6'd0;
        b0.d_wdata = '0;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge clk);
            chk("gnt_excl", c, 64'(b0.if_gnt & b0.d_gnt), Z64);
            chk("rv_excl",  c, 64'(b0.if_rvalid & b0.d_rvalid), Z64);
            if (b0.if_gnt || b0.d_gnt) begin
                gnt_seq[ng] = b0.d_gnt;
                ng++;
            end
        end
        chk("starve_grants", 0, 64'(ng), 64'd10);
        for (int k = 0; k < ng; k++)
            chk("starve_order", k, 64'(gnt_seq[k]),
                (k == 4 || k == 9) ? 64'(REQ_IF) : 64'(REQ_D));
        @(posedge clk);
        #1;
        b0.if_req = 1'b0;
        b0.d_req  = 1'b0;

        // Reset in the middle of a MEM_LAT=2 read.
        @(posedge clk);
        #1;
        rst1      = 1'b0;
        b1.d_req  = 1'b1;
        b1.d_addr = 6'd9;
        @(negedge clk);
        chk("mid_gnt", 0, 64'(b1.d_gnt), 64'd1);
        @(posedge clk);
        #1;
        b1.d_req = 1'b0;
        rst1     = 1'b1;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b1.d_rvalid) seen++;
        end
        chk("mid_no_rvalid", 0, 64'(seen), Z64);
        chk("mid_state", 0, 64'(u1.state_q), 64'(IDLE));
        chk("mid_rdata", 0, b1.d_rdata, Z64);

        @(posedge clk);
        #1;
        b1.d_req  = 1'b1;
        b1.d_addr = 6'd9;
        @(negedge clk);
        chk("re_gnt", 0, 64'(b1.d_gnt), 64'd1);
        chk("re_addr", 0, 64'(b1.mem_addr), 64'd9);
        @(posedge clk);
        #1;
        b1.d_req = 1'b0;
        lat    = 0;
        got_rv = 1'b0;
        for (int c = 0; c < 10 && !got_rv; c++) begin
            @(negedge clk);
            lat++;
            got_rv = b1.d_rvalid;
        end
        chk("re_rvalid", 0, 64'(got_rv), 64'd1);
        chk("re_lat", 0, 64'(lat), 64'd3);
        chk("re_rdata", 0, b1.d_rdata, MC);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch port and the data port of the polirv core.
- Replaces the separate instruction and data paths into memoria, so one memory array serves both fetches and loads/stores.
- Fixed priority to data, with a starvation guard for fetches.
- Multi-cycle access FSM with a req/gnt/rvalid handshake on each side.

Parameters:
- ADDR_W, 6, word address width on both requester ports and the memory port.
- DATA_W, 64, data word width.
- INSTR_W, 32, instruction width; must equal DATA_W/2.
- MEM_LAT, 1, cycles from mem_en to mem_rdata valid; must be >= 1.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before the fetch is forced.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  instruction address, in 32-bit units
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  INSTR_W  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: read data valid, or write acknowledge
- d_rdata  out  DATA_W  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE; latency counter = 0; starvation counter = 0.
  - All outputs 0, including if_rdata and d_rdata.
  - Any in-flight access is discarded: no rvalid is produced for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE or RESP with at least one req high = grant cycle T:
  - gnt and mem_en are combinational from req in that cycle.
  - The FSM latches the winner ID, write flag and if_addr[0].
  - Next state is WAIT, counter loaded with MEM_LAT.
  - No req high: IDLE stays IDLE; RESP returns to IDLE.
- WAIT:
  - Counter decrements each cycle; no grants issued; mem_en = 0.
  - When the counter reaches 0 (cycle T+MEM_LAT), mem_rdata is captured into the winner's rdata register. Writes leave rdata unchanged.
  - Next state is RESP.
- RESP:
  - Winner's rvalid = 1 for exactly one cycle, at T+MEM_LAT+1.
  - A new grant is allowed in the same cycle (back-to-back throughput: one access per MEM_LAT+1 cycles).
- Memory port driving in the grant cycle:
  - Data winner: mem_addr = d_addr, mem_we = d_we, mem_wdata = d_wdata.
  - Fetch winner: mem_addr = {0, if_addr[ADDR_W-1:1]}, mem_we = 0, mem_wdata = 0.
  - Outside grant cycles all mem_* outputs are 0.
- Fetch half select:
  - if_addr[0] = 0 -> if_rdata = mem_rdata[31:0].
  - if_addr[0] = 1 -> if_rdata = mem_rdata[63:32].
- Arbitration:
  - Only one requester is high -> it wins.
  - Both high -> data wins, unless starvation counter == STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments on each data grant while if_req = 1; saturates at STARVE_MAX.
  - Clears on a fetch grant or whenever if_req = 0.
- Handshake rules:
  - Requester fields are sampled only in the grant cycle.
  - Requests arriving during WAIT see no gnt until the next arbitration cycle.
- Hold and pulse rules:
  - rdata registers hold their value between responses.
  - gnt and rvalid are never high for both requesters in the same cycle.

Decomposition:
- Package mem_arb_pkg:
  - FSM state enum (IDLE, WAIT, RESP).
  - Requester ID constants (REQ_IF = 0, REQ_D = 1).
  - Default width constants.
- Sub-module mem_arb_prio:
  - Combinational winner select plus the starvation counter register.
  - Inputs: if_req, d_req, arbitrate enable.
  - Outputs: winner ID, grant valid.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with if_req = 1 and d_req = 1 -> all outputs 0, no mem_en; first grant occurs in the cycle after rst falls.
- Single fetch: if_addr = 5, memory word 2 = 64'hAAAA_BBBB_1111_2222, MEM_LAT = 1 -> at T: if_gnt = 1, mem_en = 1, mem_addr = 2; at T+2: if_rvalid = 1, if_rdata = 32'hAAAA_BBBB. Repeat with if_addr = 4 -> 32'h1111_2222.
- Data write then read: write d_addr = 7, d_wdata = 64'hDEAD_BEEF_0123_4567 -> mem_we = 1 at T, d_rvalid at T+2, d_rdata unchanged. Then read addr 7 -> d_rdata = 64'hDEAD_BEEF_0123_4567.
- Contention: if_req and d_req rise together -> d_gnt at T, if_gnt at T+2, d_rvalid at T+2, if_rvalid at T+4.
- Starvation: d_req and if_req held high, STARVE_MAX = 4 -> grant order D, D, D, D, I, D, D, D, D, I.
- Reset mid-access: rst = 1 at T+1 after a d_req read grant with MEM_LAT = 2 -> no d_rvalid ever; FSM in IDLE; next request granted normally with correct data.
